// File: rtl/shell_projectile.sv
// shell_projectile: one ballistic shell per tank, launched on a shoot edge.
// Flies with integer velocity and divided gravity, then hit/miss/explode.
//
// Ports:
//   frame_clk, Reset       frame clock, synchronous active-high reset
//   shoot                  fire request level; rising edge fires
//   TankX, TankY           own tank position
//   Direction              0 = left, anything else = right
//   y_component            signed launch-angle adjust (+ = flatter)
//   TargetX, TargetY       opposing tank position
//   TerrainY               terrain height under the current ShellX
//   ShellX, ShellY, ShellS shell position and size for the renderer
//   active, exploding      in flight / holding the explosion
//   hit, miss              one-cycle end-of-shot pulses
module shell_projectile #(
  parameter int VX_SPEED       = 2,
  parameter int LAUNCH_VY      = 8,
  parameter int GRAV_DIV       = 4,
  parameter int VY_MAX         = 15,
  parameter int MUZZLE_X       = 6,
  parameter int MUZZLE_Y       = 4,
  parameter int HIT_R          = 6,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       shoot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  input  logic [9:0] TerrainY,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic [9:0] ShellS,
  output logic       active,
  output logic       exploding,
  output logic       hit,
  output logic       miss
);

  localparam int GW =
    (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int EW =
    (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

  localparam logic [GW-1:0] GRAV_LAST =
    GW'(GRAV_DIV - 1);
  localparam logic [EW-1:0] EXP_LAST =
    EW'(EXPLODE_FRAMES - 1);

  localparam logic signed [5:0]  VX_P   = 6'(VX_SPEED);
  localparam logic signed [5:0]  VY_TOP = 6'(VY_MAX);
  localparam logic signed [5:0]  VY_BOT = -6'sd31;
  localparam logic signed [11:0] VY_T12 = 12'(VY_MAX);
  localparam logic signed [11:0] VY_B12 = -12'sd31;
  localparam logic signed [11:0] HIT_R12 = 12'(HIT_R);
  localparam logic signed [11:0] X_LAST = 12'sd639;
  localparam logic signed [11:0] Y_LAST = 12'sd479;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_IMPACT
  } state_t;

  state_t state_q, state_d;

  logic signed [10:0] x_q, x_d;
  logic signed [10:0] y_q, y_d;
  logic signed [5:0]  vx_q, vx_d;
  logic signed [5:0]  vy_q, vy_d;
  logic [GW-1:0]      grav_q, grav_d;
  logic [EW-1:0]      ecnt_q, ecnt_d;
  logic               shoot_q;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic               fire;
  logic               dir_left;
  logic signed [10:0] launch_x;
  logic signed [10:0] launch_y;
  logic signed [11:0] vy_raw;
  logic signed [5:0]  launch_vy;

  logic signed [11:0] xs, ys;
  logic signed [11:0] dx, dy;
  logic signed [11:0] adx, ady;
  logic               y_on;
  logic               is_hit, is_terr, is_off;

  logic signed [10:0] x_step, y_step;
  logic signed [5:0]  vy_grav;
  logic               grav_wrap;

  // Launch values from the tank's current pose
  always_comb begin
    fire     = shoot & ~shoot_q;
    dir_left = (Direction == 2'd0);
    if (dir_left) begin
      launch_x = {1'b0, TankX} - 11'(MUZZLE_X);
    end else begin
      launch_x = {1'b0, TankX} + 11'(MUZZLE_X);
    end
    launch_y = {1'b0, TankY} - 11'(MUZZLE_Y);
    vy_raw = {{2{y_component[9]}}, y_component}
           - 12'(LAUNCH_VY);
    if (vy_raw > VY_T12) begin
      launch_vy = VY_TOP;
    end else if (vy_raw < VY_B12) begin
      launch_vy = VY_BOT;
    end else begin
      launch_vy = vy_raw[5:0];
    end
  end

  // Exit tests on the current position; y < 0 is
  // above the screen, where hit/terrain cannot occur
  always_comb begin
    xs   = {x_q[10], x_q};
    ys   = {y_q[10], y_q};
    dx   = xs - $signed({2'b00, TargetX});
    dy   = ys - $signed({2'b00, TargetY});
    adx  = dx[11] ? -dx : dx;
    ady  = dy[11] ? -dy : dy;
    y_on = ~y_q[10];
    is_hit  = y_on && (adx <= HIT_R12)
                   && (ady <= HIT_R12);
    is_terr = y_on
           && (ys >= $signed({2'b00, TerrainY}));
    is_off  = x_q[10] || (xs > X_LAST)
                      || (ys > Y_LAST);
  end

  // Motion uses the old vy; gravity lands afterwards
  always_comb begin
    x_step    = x_q + {{5{vx_q[5]}}, vx_q};
    y_step    = y_q + {{5{vy_q[5]}}, vy_q};
    grav_wrap = (grav_q == GRAV_LAST);
    if (vy_q >= VY_TOP) begin
      vy_grav = VY_TOP;
    end else begin
      vy_grav = vy_q + 6'sd1;
    end
  end

  // State register
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      grav_q  <= '0;
      ecnt_q  <= '0;
      shoot_q <= 1'b1;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      grav_q  <= grav_d;
      ecnt_q  <= ecnt_d;
      shoot_q <= shoot;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    grav_d  = grav_q;
    ecnt_d  = ecnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          state_d = S_FLIGHT;
          x_d     = launch_x;
          y_d     = launch_y;
          vx_d    = dir_left ? -VX_P : VX_P;
          vy_d    = launch_vy;
          grav_d  = '0;
        end
      end
      S_FLIGHT: begin
        if (is_hit) begin
          state_d = S_IMPACT;
          hit_d   = 1'b1;
          ecnt_d  = '0;
        end else if (is_terr) begin
          state_d = S_IMPACT;
          miss_d  = 1'b1;
          ecnt_d  = '0;
        end else if (is_off) begin
          state_d = S_IDLE;
          miss_d  = 1'b1;
        end else begin
          x_d = x_step;
          y_d = y_step;
          if (grav_wrap) begin
            grav_d = '0;
            vy_d   = vy_grav;
          end else begin
            grav_d = grav_q + 1'b1;
          end
        end
      end
      S_IMPACT: begin
        if (ecnt_q == EXP_LAST) begin
          state_d = S_IDLE;
        end else begin
          ecnt_d = ecnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    active    = (state_q == S_FLIGHT);
    exploding = (state_q == S_IMPACT);
    hit       = hit_q;
    miss      = miss_q;
    ShellX    = x_q[9:0];
    ShellY    = y_q[10] ? 10'd0 : y_q[9:0];
    ShellS    = 10'd2;
  end

endmodule

// File: tb/tb_shell_projectile.sv
// tb_shell_projectile: vector table, directed corners and random shots
// checked against a frame-level ballistic model.
module tb_shell_projectile;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       shoot = 1'b0;
  logic [9:0] TankX = '0;
  logic [9:0] TankY = '0;
  logic [1:0] Direction = '0;
  logic [9:0] y_component = '0;
  logic [9:0] TargetX = 10'd1000;
  logic [9:0] TargetY = 10'd1000;
  logic [9:0] TerrainY = 10'd479;
  logic [9:0] ShellX, ShellY, ShellS;
  logic       active, exploding, hit, miss;

  shell_projectile dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .shoot      (shoot),
    .TankX      (TankX),
    .TankY      (TankY),
    .Direction  (Direction),
    .y_component(y_component),
    .TargetX    (TargetX),
    .TargetY    (TargetY),
    .TerrainY   (TerrainY),
    .ShellX     (ShellX),
    .ShellY     (ShellY),
    .ShellS     (ShellS),
    .active     (active),
    .exploding  (exploding),
    .hit        (hit),
    .miss       (miss)
  );

  always #5 frame_clk = ~frame_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 flying, 2 exploding.
  // vy is derived from frames flown rather than tracked.
  int m_phase = 0;
  int m_x = 0, m_y = 0, m_vx = 0, m_vy0 = 0;
  int m_fn = 0, m_ec = 0;
  bit m_sp = 1'b1;
  bit m_hit = 1'b0, m_miss = 1'b0;

  task automatic model_step();
    int vy, yc, tx, ty, tr, ax, ay;
    bit fire;
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (Reset) begin
      m_phase = 0; m_x = 0; m_y = 0;
      m_sp = 1'b1; m_fn = 0; m_ec = 0;
      return;
    end
    fire = shoot && !m_sp;
    m_sp = shoot;
    tx = int'(TargetX);
    ty = int'(TargetY);
    tr = int'(TerrainY);
    case (m_phase)
      0: if (fire) begin
        m_vx = (Direction == 2'd0) ? -2 : 2;
        m_x  = int'(TankX) + 3 * m_vx;
        m_y  = int'(TankY) - 4;
        yc   = int'($signed(y_component));
        m_vy0 = yc - 8;
        if (m_vy0 > 15) m_vy0 = 15;
        if (m_vy0 < -31) m_vy0 = -31;
        m_fn = 0;
        m_phase = 1;
      end
      1: begin
        vy = m_vy0 + m_fn / 4;
        if (vy > 15) vy = 15;
        ax = (m_x > tx) ? m_x - tx : tx - m_x;
        ay = (m_y > ty) ? m_y - ty : ty - m_y;
        if (m_y >= 0 && ax <= 6 && ay <= 6) begin
          m_hit = 1'b1; m_phase = 2; m_ec = 0;
        end else if (m_y >= 0 && m_y >= tr) begin
          m_miss = 1'b1; m_phase = 2; m_ec = 0;
        end else if (m_x < 0 || m_x > 639
                     || m_y > 479) begin
          m_miss = 1'b1; m_phase = 0;
        end else begin
          m_x += m_vx;
          m_y += vy;
          m_fn++;
        end
      end
      default: begin
        m_ec++;
        if (m_ec == 8) m_phase = 0;
      end
    endcase
  endtask

  task automatic tick();
    logic [9:0] ey;
    model_step();
    @(posedge frame_clk);
    #1;
    ey = (m_y < 0) ? 10'd0 : 10'(m_y);
    check("model",
      {8'd0, active, exploding, hit, miss,
       ShellX, ShellY},
      {8'd0, m_phase == 1, m_phase == 2,
       m_hit, m_miss, 10'(m_x), ey});
  endtask

  task automatic fire_shot(input int tx, input int ty,
                           input int dir, input int yc);
    TankX = 10'(tx);
    TankY = 10'(ty);
    Direction = 2'(dir);
    y_component = 10'(yc);
    shoot = 1'b1;
    tick();
    shoot = 1'b0;
  endtask

  task automatic run_shot(input int budget,
                          output int nh, output int nm,
                          output int ne);
    nh = 0; nm = 0; ne = 0;
    for (int i = 0; i < budget && (active || exploding);
         i++) begin
      tick();
      nh += int'(hit);
      nm += int'(miss);
      ne += int'(exploding);
    end
    check("shot_ends", 32'(active | exploding), 0);
  endtask

  typedef struct {
    logic       shoot;
    logic       act;
    logic [9:0] sx;
    logic [9:0] sy;
  } vec_t;

  vec_t tbl[8];
  int   xs[64];
  int   ys[64];

  initial begin
    int nh, nm, ne, nrec, rises, t;
    bit pa;

    tbl[0] = '{1'b0, 1'b0, 10'd0,   10'd0};
    tbl[1] = '{1'b1, 1'b1, 10'd106, 10'd296};
    tbl[2] = '{1'b1, 1'b1, 10'd108, 10'd288};
    tbl[3] = '{1'b0, 1'b1, 10'd110, 10'd280};
    tbl[4] = '{1'b1, 1'b1, 10'd112, 10'd272};
    tbl[5] = '{1'b1, 1'b1, 10'd114, 10'd264};
    tbl[6] = '{1'b0, 1'b1, 10'd116, 10'd257};
    tbl[7] = '{1'b0, 1'b1, 10'd118, 10'd250};

    // Reset with shoot high must not fire
    Reset = 1'b1;
    shoot = 1'b1;
    tick();
    check("rst_state",
      {active, exploding, hit, miss, ShellX, ShellY}, 0);
    check("shell_s", 32'(ShellS), 2);
    Reset = 1'b0;
    shoot = 1'b0;

    // Launch trajectory table
    TankX = 10'd100; TankY = 10'd300;
    Direction = 2'd1; y_component = 10'd0;
    TerrainY = 10'd479;
    for (int i = 0; i < 8; i++) begin
      shoot = tbl[i].shoot;
      tick();
      check($sformatf("tbl%0d_act", i),
            32'(active), 32'(tbl[i].act));
      check($sformatf("tbl%0d_x", i),
            32'(ShellX), 32'(tbl[i].sx));
      check($sformatf("tbl%0d_y", i),
            32'(ShellY), 32'(tbl[i].sy));
    end

    // Reset mid-flight with shoot held
    shoot = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    check("rst_flight",
      {active, exploding, hit, miss, ShellX, ShellY}, 0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_no_fire", 32'(active), 0);
    end
    shoot = 1'b0;
    tick();

    // Hit on the trajectory point (112, 272)
    TargetX = 10'd112; TargetY = 10'd272;
    fire_shot(100, 300, 1, 0);
    run_shot(100, nh, nm, ne);
    check("hit_pulses", 32'(nh), 1);
    check("hit_miss", 32'(nm), 0);
    check("hit_expl", 32'(ne), 8);
    check("hit_hold_x", 32'(ShellX), 112);
    check("hit_hold_y", 32'(ShellY), 272);
    TargetX = 10'd1000; TargetY = 10'd1000;

    // Terrain impact
    TerrainY = 10'd250;
    fire_shot(100, 200, 1, 0);
    run_shot(300, nh, nm, ne);
    check("ter_miss", 32'(nm), 1);
    check("ter_hit", 32'(nh), 0);
    check("ter_expl", 32'(ne), 8);

    // Off-screen right: 636, 638, 640 then exit
    TerrainY = 10'd479;
    fire_shot(630, 300, 1, 0);
    run_shot(50, nh, nm, ne);
    check("off_miss", 32'(nm), 1);
    check("off_expl", 32'(ne), 0);
    check("off_hold_x", 32'(ShellX), 640);

    // Left fire with gravity cap
    TerrainY = 10'd1023;
    fire_shot(600, 4, 0, 20);
    nrec = 0;
    xs[0] = int'(ShellX);
    ys[0] = int'(ShellY);
    nrec = 1;
    for (int i = 0; i < 60 && active; i++) begin
      tick();
      if (active && nrec < 64) begin
        xs[nrec] = int'(ShellX);
        ys[nrec] = int'(ShellY);
        nrec++;
      end
    end
    check("grav_len", 32'(nrec > 22), 1);
    check("left_x0", 32'(xs[0]), 594);
    check("left_dx", 32'(xs[6] - xs[5]), -32'sd2);
    check("grav_d0", 32'(ys[1] - ys[0]), 12);
    check("grav_d3", 32'(ys[4] - ys[3]), 12);
    check("grav_d4", 32'(ys[5] - ys[4]), 13);
    check("grav_d11", 32'(ys[12] - ys[11]), 14);
    check("grav_d12", 32'(ys[13] - ys[12]), 15);
    check("grav_d20", 32'(ys[21] - ys[20]), 15);
    run_shot(60, nh, nm, ne);

    // Fire gating: hold then toggle through flight/explosion
    TerrainY = 10'd250;
    TankX = 10'd100; TankY = 10'd200;
    Direction = 2'd1; y_component = 10'd0;
    shoot = 1'b1;
    tick();
    rises = int'(active);
    pa = active;
    nm = 0; ne = 0;
    for (int i = 0; i < 320; i++) begin
      if (i >= 20) shoot = ~shoot;
      if (i >= 20 && !active && !exploding) break;
      tick();
      if (active && !pa) rises++;
      pa = active;
      nm += int'(miss);
      ne += int'(exploding);
    end
    check("gate_done", 32'(active | exploding), 0);
    shoot = 1'b0;
    tick();
    tick();
    check("gate_rises", 32'(rises), 1);
    check("gate_miss", 32'(nm), 1);
    check("gate_expl", 32'(ne), 8);
    check("gate_idle", 32'(active), 0);
    shoot = 1'b1;
    tick();
    check("gate_refire", 32'(active), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    shoot = 1'b0;
    tick();

    // Random shots with shoot noise
    for (int s = 0; s < 40; s++) begin
      TerrainY = 10'($urandom_range(200, 479));
      Direction = 2'($urandom_range(0, 3));
      TankX = 10'($urandom_range(10, 620));
      TankY = 10'($urandom_range(20, 470));
      t = int'(TankX);
      if (Direction == 2'd0)
        t -= int'($urandom_range(0, 120));
      else
        t += int'($urandom_range(0, 120));
      if (t < 0) t = 0;
      TargetX = 10'(t);
      t = int'(TankY) - int'($urandom_range(0, 150));
      if (t < 0) t = 0;
      TargetY = 10'(t);
      y_component =
        10'(int'($urandom_range(0, 40)) - 10);
      shoot = 1'b1;
      tick();
      for (int i = 0; i < 600 && (active || exploding);
           i++) begin
        shoot = 1'($urandom_range(0, 1));
        tick();
      end
      check("rnd_ends", 32'(active | exploding), 0);
      shoot = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: bench did not reach summary");
    $fatal(1, "watchdog expired");
  end

endmodule
